// File: rtl/mac_seq.sv
// Purpose : queues (activation, weight) pairs and feeds them one at a time to an
//           external MAC. The MAC output is fed back as the next partial sum, and
//           the finished dot product is presented after len pairs.
// Latency : start at edge T with a pre-filled FIFO -> pair k issued at edge
//           T+1+k*(mac_lat+1); out_valid pulses in the cycle after the last pair's
//           result is sampled.
// Backpr. : in_ready = FIFO not full (and not in reset). A pop does not free a slot
//           in the same cycle it happens.
// Ports   : clk/reset (sync, active-high); start; in_valid/in_ready/in_a/in_b;
//           mac_a/mac_b/mac_c -> MAC; mac_out <- MAC; out_valid/out_psum; busy.

module mac_seq #(
    parameter int bw         = 4,
    parameter int psum_bw    = 16,
    parameter int len        = 20,
    parameter int fifo_depth = 4,
    parameter int mac_lat    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [bw-1:0]      in_a,
    input  logic [bw-1:0]      in_b,
    output logic [bw-1:0]      mac_a,
    output logic [bw-1:0]      mac_b,
    output logic [psum_bw-1:0] mac_c,
    input  logic [psum_bw-1:0] mac_out,
    output logic               out_valid,
    output logic [psum_bw-1:0] out_psum,
    output logic               busy
);

    localparam int AW = $clog2(fifo_depth);
    localparam int CW = (len > 1) ? $clog2(len) : 1;
    localparam int WW = (mac_lat > 1) ? $clog2(mac_lat) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO: {a, b} per entry, pointers wrap naturally (depth is 2^AW).
    // ------------------------------------------------------------------
    logic [2*bw-1:0] mem [fifo_depth];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     occ;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [bw-1:0]   head_a;
    logic [bw-1:0]   head_b;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WW-1:0]   wcnt;
    logic [psum_bw-1:0] psum;

    assign full     = (occ == (AW+1)'(fifo_depth));
    assign empty    = (occ == '0);
    // in_ready depends only on registered occupancy, so a same-cycle pop
    // never lets a push into a full FIFO.
    assign in_ready = !full && !reset;
    assign push     = in_valid && in_ready;
    assign pop      = (state == ISSUE) && !empty;
    assign head_a   = mem[rd_ptr][2*bw-1:bw];
    assign head_b   = mem[rd_ptr][bw-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM. wcnt counts the edges remaining until mac_out holds the
    // result of the pair issued last; at wcnt==0 that edge is exactly mac_lat
    // edges after the issue edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            wcnt      <= '0;
            psum      <= '0;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_c     <= '0;
            out_psum  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        psum  <= '0;
                        cnt   <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!empty) begin
                        mac_a <= head_a;
                        mac_b <= head_b;
                        mac_c <= psum;
                        wcnt  <= WW'(mac_lat - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (wcnt != '0) begin
                        wcnt <= wcnt - 1'b1;
                    end else begin
                        psum <= mac_out;
                        if (cnt == CW'(len - 1)) begin
                            out_psum  <= mac_out;
                            out_valid <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Upstream sequencer for the mac_wrapper MAC stage.
- Buffers incoming (activation, weight) pairs in a small FIFO and issues them to the MAC one at a time.
- Feeds the MAC's own output back as the next partial sum.
- After `len` pairs, presents the finished dot-product psum to the downstream consumer.

Parameters:
- bw, 4, activation/weight width (activation unsigned, weight two's complement)
- psum_bw, 16, partial-sum width
- len, 20, pairs per dot product (≥1)
- fifo_depth, 4, input FIFO entries (power of 2, ≥2)
- mac_lat, 2, edges from issue to valid mac_out (≥1)

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  begin new dot product (sampled in IDLE only)
- in_valid  input  1  in_a/in_b valid
- in_ready  output  1  FIFO can accept
- in_a  input  bw  activation (unsigned)
- in_b  input  bw  weight (signed)
- mac_a  output  bw  to mac_wrapper a
- mac_b  output  bw  to mac_wrapper b
- mac_c  output  psum_bw  to mac_wrapper c
- mac_out  input  psum_bw  from mac_wrapper out
- out_valid  output  1  one-cycle pulse, out_psum final
- out_psum  output  psum_bw  finished dot product
- busy  output  1  FSM not IDLE

Behaviour:
- Reset (sync, high):
  - FIFO flushed; state=IDLE; psum=0; pair count=0.
  - mac_a, mac_b, mac_c, out_psum = 0; out_valid = 0; busy = 0.
  - in_ready forced 0 while reset is high.
- FIFO:
  - in_ready = !full (and !reset).
  - Push on in_valid && in_ready.
  - No push when full, even if a pop occurs the same cycle (no bypass).
  - Push and pop in the same cycle when not full: occupancy unchanged.
  - Contents persist across dot products; start does not flush.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - start=1 → psum<=0, cnt<=0, go ISSUE.
  - start is ignored in ISSUE/WAIT.
- ISSUE:
  - FIFO empty → stay; mac_* hold.
  - Non-empty → pop head; mac_a<=a, mac_b<=b, mac_c<=psum; wcnt<=mac_lat-1; go WAIT.
- WAIT:
  - wcnt≠0 → wcnt--.
  - wcnt==0 → psum<=mac_out, i.e. sampled exactly mac_lat edges after the issue edge.
  - If cnt==len-1: out_psum<=mac_out, out_valid<=1, go IDLE. Else cnt++, go ISSUE.
- Throughput: one pair per mac_lat+1 cycles while the FIFO is non-empty.
- Timing: start sampled at edge T with FIFO pre-filled → pair k issued at edge T+1+k(mac_lat+1); out_valid high for the single cycle after edge T+(len-1)(mac_lat+1)+1+mac_lat.
- out_valid: exactly one cycle. out_psum holds until the next completion or reset.
- mac_a/mac_b/mac_c: registered; change only on issue edges or reset.
- Arithmetic: psum is stored verbatim from mac_out; sign interpretation (unsigned a × signed b + signed c, mod 2^psum_bw) belongs to the MAC. No saturation.
- Reset mid-operation: immediate abort; no out_valid; queued pairs discarded.
- start in the same cycle as final completion (state≠IDLE) is ignored; it must be reasserted in IDLE.

Test Plan:
- Reset → all outputs 0, in_ready=0 during reset; one cycle after release in_ready=1, busy=0.
- Continuous feed, 20 pairs a=3, b=4'b1110 (−2), behavioural MAC lat 2, start at edge T → single out_valid cycle after edge T+60, out_psum=16'hFF88 (−120).
- Extremes:
  - 20× a=15, b=4'b1000 (−8) → out_psum=16'hF6A0 (−2400).
  - 20× a=15, b=7 → 16'h0834 (2100).
- Backpressure: no start, push 5 pairs back-to-back → in_ready drops after 4th accepted. 5th accepted the cycle after the first pop once start is given; final psum counts all pairs in order.
- Starvation: in_valid gapped 7 cycles between pairs → FSM idles in ISSUE, mac_a/b/c stable during gaps; result equals the ungapped result.
- Reset after 5 pairs issued → no out_valid, psum/mac_* = 0. A fresh start with 20 pairs a=1, b=1 → out_psum=16'h0014.
